// File: rtl/interp_rate_sequencer_pkg.sv
// interp_seq_pkg: shared state encoding, default rate ratios and counter
// sizing helpers for the interpolation-chain rate sequencer.
package interp_seq_pkg;

   // Sequencer operating states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

   // Default rate ratios for the halfband chain.
   localparam int DEF_CLK_PER_FAST = 2;
   localparam int DEF_FAST_PER_SAM = 2;
   localparam int DEF_SAM_PER_SYM  = 4;
   localparam int DEF_FLUSH_SYMS   = 2;

   // Number of clk cycles in one symbol period.
   function automatic int sym_period(input int clk_per_fast,
                                     input int fast_per_sam,
                                     input int sam_per_sym);
      return clk_per_fast * fast_per_sam * sam_per_sym;
   endfunction

   // Width of a counter that runs 0..modulus-1, never narrower than one bit.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/interp_rate_sequencer_counter.sv
// mod_counter: modulo-MOD up counter with enable, synchronous clear and a
// combinational wrap flag used to cascade the rate counters.
module mod_counter
   import interp_seq_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = cnt_width(MOD)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   // The counter wraps on the enabled cycle in which it sits at its last
   // value; with MOD=1 that is every enabled cycle.
   assign wrap = en && (cnt == W'(MOD - 1));

   // Count register: clear has priority so a realign always lands on 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/interp_rate_sequencer.sv
// interp_rate_sequencer: single source of the fast/sample/symbol enables and
// MAC/symbol phase selects for the time-shared interpolation chain, with a
// start/stop controller that zero-fills the delay lines before idling.
module interp_rate_sequencer
   import interp_seq_pkg::*;
#(
   parameter int CLK_PER_FAST = DEF_CLK_PER_FAST,
   parameter int FAST_PER_SAM = DEF_FAST_PER_SAM,
   parameter int SAM_PER_SYM  = DEF_SAM_PER_SYM,
   parameter int FLUSH_SYMS   = DEF_FLUSH_SYMS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                stop,
   input  logic                                sync_req,
   output logic                                fast_en,
   output logic                                sam_clk_en,
   output logic                                sym_clk_en,
   output logic [cnt_width(FAST_PER_SAM)-1:0]  mac_phase,
   output logic [cnt_width(SAM_PER_SYM)-1:0]   sym_phase,
   output logic                                zero_fill,
   output logic                                running,
   output logic                                flush_done
);

   localparam int CW = cnt_width(CLK_PER_FAST);
   localparam int FW = cnt_width(FAST_PER_SAM);
   localparam int SW = cnt_width(SAM_PER_SYM);
   localparam int XW = cnt_width(FLUSH_SYMS);

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic          stop_pend;
   logic          stop_pend_nxt;

   logic          active;
   logic          rate_clr;
   logic          run_nxt;

   logic [CW-1:0] clk_cnt;
   logic          clk_wrap;
   logic [FW-1:0] fast_cnt;
   logic          fast_wrap;
   logic          fast_step;
   logic [SW-1:0] sam_cnt;
   logic          sam_wrap;
   logic          sam_step;
   logic [XW-1:0] flush_cnt;
   logic          flush_wrap;
   logic          flush_step;
   logic          flush_clr;

   logic          clk_zero_nxt;
   logic          fast_zero_nxt;
   logic          sam_zero_nxt;

   // Rate counters only move while running; a realign request is honoured
   // only then. The sample counter wrapping marks the symbol boundary.
   assign active     = (state != IDLE);
   assign rate_clr   = active && sync_req;
   assign fast_step  = active && clk_wrap;
   assign sam_step   = fast_wrap;
   assign flush_step = (state == FLUSH) && sam_wrap;
   assign flush_clr  = (state != FLUSH) && (flush_cnt != '0);

   mod_counter #(.MOD(CLK_PER_FAST)) u_clk_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (active),
      .clr   (rate_clr),
      .cnt   (clk_cnt),
      .wrap  (clk_wrap)
   );

   mod_counter #(.MOD(FAST_PER_SAM)) u_fast_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (fast_step),
      .clr   (rate_clr),
      .cnt   (fast_cnt),
      .wrap  (fast_wrap)
   );

   mod_counter #(.MOD(SAM_PER_SYM)) u_sam_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (sam_step),
      .clr   (rate_clr),
      .cnt   (sam_cnt),
      .wrap  (sam_wrap)
   );

   // The flush symbol count deliberately ignores realign requests.
   mod_counter #(.MOD(FLUSH_SYMS)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (flush_step),
      .clr   (flush_clr),
      .cnt   (flush_cnt),
      .wrap  (flush_wrap)
   );

   // Predict whether each counter will hold 0 after this edge so the strobes
   // can be registered and still line up with the counter values they mark.
   assign clk_zero_nxt  = rate_clr || clk_wrap  || (!active    && (clk_cnt  == '0));
   assign fast_zero_nxt = rate_clr || fast_wrap || (!fast_step && (fast_cnt == '0));
   assign sam_zero_nxt  = rate_clr || sam_wrap  || (!sam_step  && (sam_cnt  == '0));
   assign run_nxt       = (state_nxt != IDLE);

   // State and pending-stop registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         stop_pend <= 1'b0;
      end else begin
         state     <= state_nxt;
         stop_pend <= stop_pend_nxt;
      end
   end

   // Next-state logic: a stop is parked until the next symbol boundary so the
   // flush always starts on a whole symbol; the flush ends on its final wrap.
   always_comb begin
      state_nxt     = state;
      stop_pend_nxt = stop_pend;
      unique case (state)
         IDLE: begin
            stop_pend_nxt = 1'b0;
            if (start) begin
               state_nxt     = RUN;
               stop_pend_nxt = stop;
            end
         end
         RUN: begin
            if (stop_pend && sam_wrap) begin
               state_nxt     = FLUSH;
               stop_pend_nxt = 1'b0;
            end else if (stop) begin
               stop_pend_nxt = 1'b1;
            end
         end
         FLUSH: begin
            stop_pend_nxt = 1'b0;
            if (flush_wrap) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
         end
      endcase
   end

   // Registered strobes and status; nothing strobes once the next state is
   // IDLE, so leaving FLUSH shows only the flush_done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fast_en    <= 1'b0;
         sam_clk_en <= 1'b0;
         sym_clk_en <= 1'b0;
         zero_fill  <= 1'b0;
         running    <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         fast_en    <= run_nxt && clk_zero_nxt;
         sam_clk_en <= run_nxt && clk_zero_nxt && fast_zero_nxt;
         sym_clk_en <= run_nxt && clk_zero_nxt && fast_zero_nxt && sam_zero_nxt;
         zero_fill  <= (state_nxt == FLUSH);
         running    <= run_nxt;
         flush_done <= (state == FLUSH) && (state_nxt == IDLE);
      end
   end

   // The phase selects are the counter registers themselves.
   assign mac_phase = fast_cnt;
   assign sym_phase = sam_cnt;

endmodule

// File: tb/tb_interp_rate_sequencer.sv
// tb_interp_rate_sequencer: scoreboard bench driving a default-ratio sequencer
// and a CLK_PER_FAST=1 / FAST_PER_SAM=4 / SAM_PER_SYM=1 sequencer in parallel.
module tb_interp_rate_sequencer;
   import interp_seq_pkg::*;

   localparam int A_CPF = 2;
   localparam int A_FPS = 2;
   localparam int A_SPS = 4;
   localparam int A_FS  = 2;
   localparam int B_CPF = 1;
   localparam int B_FPS = 4;
   localparam int B_SPS = 1;
   localparam int B_FS  = 2;

   typedef struct {
      int st;
      int pos;
      int fsym;
      bit pend;
      bit done;
   } model_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic stop;
   logic sync_req;

   logic fast_a, sam_a, sym_a, zf_a, run_a, done_a;
   logic [cnt_width(A_FPS)-1:0] mac_a;
   logic [cnt_width(A_SPS)-1:0] sph_a;
   logic fast_b, sam_b, sym_b, zf_b, run_b, done_b;
   logic [cnt_width(B_FPS)-1:0] mac_b;
   logic [cnt_width(B_SPS)-1:0] sph_b;

   int vecCount   = 0;
   int missCount  = 0;
   int zfCountA   = 0;
   int doneCountA = 0;
   int runOnlyA   = 0;

   model_t mA;
   model_t mB;
   logic [15:0] expQA[$];
   logic [15:0] expQB[$];

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   interp_rate_sequencer #(
      .CLK_PER_FAST (A_CPF),
      .FAST_PER_SAM (A_FPS),
      .SAM_PER_SYM  (A_SPS),
      .FLUSH_SYMS   (A_FS)
   ) dut_a (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .sync_req   (sync_req),
      .fast_en    (fast_a),
      .sam_clk_en (sam_a),
      .sym_clk_en (sym_a),
      .mac_phase  (mac_a),
      .sym_phase  (sph_a),
      .zero_fill  (zf_a),
      .running    (run_a),
      .flush_done (done_a)
   );

   interp_rate_sequencer #(
      .CLK_PER_FAST (B_CPF),
      .FAST_PER_SAM (B_FPS),
      .SAM_PER_SYM  (B_SPS),
      .FLUSH_SYMS   (B_FS)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .sync_req   (sync_req),
      .fast_en    (fast_b),
      .sam_clk_en (sam_b),
      .sym_clk_en (sym_b),
      .mac_phase  (mac_b),
      .sym_phase  (sph_b),
      .zero_fill  (zf_b),
      .running    (run_b),
      .flush_done (done_b)
   );

   // Flatten one cycle of outputs into a single word for comparison.
   function automatic logic [15:0] packOut(input bit f, input bit s, input bit y,
                                           input bit z, input bit r, input bit d,
                                           input int mac, input int sph);
      return {f, s, y, z, r, d, 2'b00, mac[3:0], sph[3:0]};
   endfunction

   function automatic logic [15:0] obsA();
      return packOut(fast_a, sam_a, sym_a, zf_a, run_a, done_a, int'(mac_a), int'(sph_a));
   endfunction

   function automatic logic [15:0] obsB();
      return packOut(fast_b, sam_b, sym_b, zf_b, run_b, done_b, int'(mac_b), int'(sph_b));
   endfunction

   function automatic model_t modelReset();
      model_t m;
      m.st   = 0;
      m.pos  = 0;
      m.fsym = 0;
      m.pend = 1'b0;
      m.done = 1'b0;
      return m;
   endfunction

   // Reference model: one position counter across the whole symbol period.
   function automatic model_t modelStep(input model_t m, input int cpf, input int fps,
                                        input int sps, input int fsyms,
                                        input bit s, input bit p, input bit y);
      model_t n;
      int     period;
      bit     atEnd;
      n      = m;
      period = sym_period(cpf, fps, sps);
      atEnd  = (m.pos == period - 1);
      n.done = 1'b0;
      case (m.st)
         0: begin
            if (s) begin
               n.st   = 1;
               n.pos  = 0;
               n.pend = p;
            end
         end
         1: begin
            n.pos = (y || atEnd) ? 0 : m.pos + 1;
            if (atEnd && m.pend) begin
               n.st   = 2;
               n.fsym = 0;
               n.pend = 1'b0;
            end else if (p) begin
               n.pend = 1'b1;
            end
         end
         default: begin
            n.pos = (y || atEnd) ? 0 : m.pos + 1;
            if (atEnd) begin
               if (m.fsym == fsyms - 1) begin
                  n.st   = 0;
                  n.fsym = 0;
                  n.done = 1'b1;
               end else begin
                  n.fsym = m.fsym + 1;
               end
            end
         end
      endcase
      return n;
   endfunction

   function automatic logic [15:0] expOut(input model_t m, input int cpf, input int fps);
      bit act;
      act = (m.st != 0);
      return packOut(act && (m.pos % cpf == 0),
                     act && (m.pos % (cpf * fps) == 0),
                     act && (m.pos == 0),
                     m.st == 2, act, m.done,
                     act ? (m.pos / cpf) % fps : 0,
                     act ? m.pos / (cpf * fps) : 0);
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what both
   // sequencers should show after the next rising edge.
   task automatic applyStimulus(input bit s, input bit p, input bit y);
      @(negedge clk);
      start    = s;
      stop     = p;
      sync_req = y;
      mA = modelStep(mA, A_CPF, A_FPS, A_SPS, A_FS, s, p, y);
      mB = modelStep(mB, B_CPF, B_FPS, B_SPS, B_FS, s, p, y);
      expQA.push_back(expOut(mA, A_CPF, A_FPS));
      expQB.push_back(expOut(mB, B_CPF, B_FPS));
   endtask

   // Idle-step until the default-ratio model reaches a given state/position.
   task automatic runUntil(input int pos, input int st);
      int n;
      n = 0;
      while (!(mA.pos == pos && mA.st == st) && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (n >= 100) begin
         checkOutput("runUntil.bound", 16'(n), 16'd0);
      end
   endtask

   // Monitor: pop the scoreboard one unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQA.size() > 0) begin
            checkOutput($sformatf("A.outs@%0t", $time), obsA(), expQA.pop_front());
            if (zf_a) zfCountA++;
            if (done_a) doneCountA++;
            if (run_a && !zf_a) runOnlyA++;
         end
         if (expQB.size() > 0) begin
            checkOutput($sformatf("B.outs@%0t", $time), obsB(), expQB.pop_front());
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      start    = 1'b0;
      stop     = 1'b0;
      sync_req = 1'b0;
      reset    = 1'b0;
      mA = modelReset();
      mB = modelReset();
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset.A", obsA(), 16'h0000);
      checkOutput("reset.B", obsB(), 16'h0000);
      reset = 1'b0;

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

      // Start pulse, then free run with a stray start that must be ignored.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus(bit'(i == 20), 1'b0, 1'b0);

      // Stop mid-symbol (sam_cnt=1): flush starts on the next symbol boundary.
      runUntil(4, 1);
      zfCountA   = 0;
      doneCountA = 0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("zfLen.stop", 16'(zfCountA), 16'(A_FS * sym_period(A_CPF, A_FPS, A_SPS)));
      checkOutput("doneCnt.stop", 16'(doneCountA), 16'd1);

      // Realign at clk_cnt=1, fast_cnt=1, sam_cnt=2.
      applyStimulus(1'b1, 1'b0, 1'b0);
      runUntil(11, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

      // Stop and sync together, then reset part-way through the flush.
      applyStimulus(1'b0, 1'b1, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
      runUntil(8, 2);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midReset.A", obsA(), 16'h0000);
      checkOutput("midReset.B", obsB(), 16'h0000);
      mA = modelReset();
      mB = modelReset();
      repeat (2) @(negedge clk);
      reset      = 1'b0;
      doneCountA = 0;
      repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("doneCnt.reset", 16'(doneCountA), 16'd0);

      // Start and stop together from IDLE: one symbol of RUN, then flush.
      zfCountA   = 0;
      doneCountA = 0;
      runOnlyA   = 0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("runLen.startStop", 16'(runOnlyA), 16'(sym_period(A_CPF, A_FPS, A_SPS)));
      checkOutput("zfLen.startStop", 16'(zfCountA), 16'(A_FS * sym_period(A_CPF, A_FPS, A_SPS)));
      checkOutput("doneCnt.startStop", 16'(doneCountA), 16'd1);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/interp_rate_sequencer.md
Name: interp_rate_sequencer

Overview:
Generates the clock-enable strobes and phase selects that sequence the time-shared halfband interpolation chain. Outputs: fast (MAC-slot) strobe, sample strobe, symbol strobe, plus MAC phase index for coefficient/tap muxing. Adds a start/stop/flush controller so the filter delay lines are drained with zeros before the chain idles. Sits between the top-level control logic and every filter/pulse-shaper stage; it is the single source of all rate enables.

Parameters:
CLK_PER_FAST, 2, clk cycles per fast_en strobe (>=1)
FAST_PER_SAM, 2, fast slots per sample, equal to the MAC time-share factor (>=2)
SAM_PER_SYM, 4, samples per symbol (>=1)
FLUSH_SYMS, 2, symbol periods of zero-fill after stop (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  level; begin strobing when IDLE
stop  in  1  level; request flush then idle
sync_req  in  1  pulse; realign all counters to phase 0
fast_en  out  1  one-clk strobe, fast slot rate
sam_clk_en  out  1  one-clk strobe, sample rate
sym_clk_en  out  1  one-clk strobe, symbol rate
mac_phase  out  $clog2(FAST_PER_SAM) (min 1)  fast-slot index within current sample
sym_phase  out  $clog2(SAM_PER_SYM) (min 1)  sample index within current symbol
zero_fill  out  1  upstream must present zero samples
running  out  1  high in RUN or FLUSH
flush_done  out  1  one-clk pulse on FLUSH->IDLE

Behaviour:
- Reset (async): state IDLE, all counters 0, every output 0.
- Counters: clk_cnt mod CLK_PER_FAST; fast_cnt mod FAST_PER_SAM advancing when clk_cnt wraps; sam_cnt mod SAM_PER_SYM advancing when fast_cnt wraps. Counters run only in RUN/FLUSH; they hold at 0 in IDLE.
- All outputs are registered. fast_en=1 in the cycle where clk_cnt==0. sam_clk_en=1 additionally requires fast_cnt==0. sym_clk_en=1 additionally requires sam_cnt==0. Coincident strobes are asserted in the same cycle.
- mac_phase=fast_cnt and sym_phase=sam_cnt, both valid every cycle and constant between fast_en strobes.
- States: IDLE, RUN, FLUSH.
- IDLE->RUN: start=1 sampled at edge N. In cycle N..N+1: running=1, counters 0, fast_en=sam_clk_en=sym_clk_en=1.
- RUN: stop=1 sets stop_pend. When stop_pend is set and the counters wrap to all-zero (symbol boundary), go to FLUSH. In that first FLUSH cycle sym_clk_en=1 and zero_fill=1.
- FLUSH: strobes continue. zero_fill=1 for exactly FLUSH_SYMS*SAM_PER_SYM*FAST_PER_SAM*CLK_PER_FAST cycles. The flush symbol counter is FLUSH_SYMS-deep.
- FLUSH->IDLE: on the final counter wrap. The next cycle has flush_done=1, running=0, zero_fill=0, no strobes.
- sync_req in RUN/FLUSH: all rate counters reset to 0 next cycle, so all three strobes fire in that cycle. The flush symbol count is not reset. sync_req in IDLE is ignored.
- start in RUN/FLUSH is ignored. stop in FLUSH is ignored. start and stop both high in IDLE: enter RUN with stop_pend set.
- sync_req and stop in the same cycle: sync applies, and stop_pend is still set.
- Mid-operation reset: immediate IDLE with all outputs 0. There are no partial strobes after reset deasserts.
- CLK_PER_FAST=1: fast_en is continuously high while running.

Decomposition:
- Package interp_seq_pkg: state enum {IDLE,RUN,FLUSH}; default parameter constants; function computing the total period per symbol.
- Sub-module mod_counter (parameter MOD; inputs en, clr; outputs cnt, wrap). Instantiate it three times for clk/fast/sam and once for flush symbols.
- The FSM and output registers live in the top module.

Test Plan:
- Defaults, start pulse after reset -> fast_en every 2 clks, sam_clk_en every 4, sym_clk_en every 16, all three high in the first RUN cycle; mac_phase 0,0,1,1 repeating; sym_phase steps 0..3.
- Stop asserted mid-symbol (sam_cnt=1) -> FLUSH begins at the next sym_clk_en; zero_fill high exactly 32 clks; flush_done one-cycle pulse; strobes stop after it.
- sync_req at clk_cnt=1, fast_cnt=1, sam_cnt=2 -> next cycle all strobes=1, mac_phase=0, sym_phase=0; sym period 16 resumes from there.
- Reset asserted during FLUSH -> all outputs 0 asynchronously; after release, no strobes until start; no flush_done.
- start and stop together in IDLE -> one full symbol (16 clks) of RUN, then FLUSH of 32 clks, then flush_done.
- CLK_PER_FAST=1, FAST_PER_SAM=4, SAM_PER_SYM=1 -> fast_en constant high, mac_phase 0,1,2,3, sam_clk_en=sym_clk_en every 4 clks.
